// File: rtl/imem_ctrl.sv
// imem_ctrl: boot-loads the instruction ROM from a byte stream, then serves IF fetches
// through a 1-deep registered request/valid pipe with stall and flush.
module imem_ctrl #(
   parameter int              XLEN       = 32,
   parameter int              ADDR_W     = 12,
   parameter logic [XLEN-1:0] MEM_OFFSET = 32'h8000_0000,
   parameter bit              BOOT_EN    = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              ld_ovf_o,
   input  logic              boot_start_i,
   output logic              boot_done_o,
   input  logic              fetch_req_i,
   input  logic [XLEN-1:0]   fetch_addr_i,
   output logic              fetch_ready_o,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              fetch_valid_o,
   output logic [XLEN-1:0]   fetch_pc_o,
   output logic [XLEN-1:0]   fetch_inst_o,
   output logic              fetch_err_o,
   output logic              rom_we_o,
   output logic [ADDR_W-1:0] rom_waddr_o,
   output logic [7:0]        rom_wdata_o,
   output logic [ADDR_W-1:0] rom_raddr_o,
   input  logic [XLEN-1:0]   rom_rdata_i
);
   localparam logic [0:0]      ST_LOAD = 1'b0;
   localparam logic [0:0]      ST_RUN  = 1'b1;
   localparam logic [XLEN-1:0] ROM_SZ  = XLEN'(2**ADDR_W);
   localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
   logic [0:0]      state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d;
   logic            err_q, err_d;
   logic            run, hs, full, accept, hold, ok;
   logic [XLEN-1:0] off;
   assign run  = state_q == ST_RUN;
   assign off  = fetch_addr_i - MEM_OFFSET;
   assign ok   = (fetch_addr_i >= MEM_OFFSET) & (off < ROM_SZ) & (fetch_addr_i[1:0] == 2'b00);
   assign full = cnt_q[ADDR_W];
   assign hs   = ld_valid_i & !run;
   assign hold = valid_q & stall_i & !flush_i;
   assign ld_ready_o    = !run;
   assign boot_done_o   = run;
   assign ld_ovf_o      = ovf_q;
   assign rom_we_o      = hs & !full;
   assign rom_waddr_o   = cnt_q[ADDR_W-1:0];
   assign rom_wdata_o   = ld_data_i;
   assign rom_raddr_o   = {off[ADDR_W-1:2], 2'b00};
   assign fetch_ready_o = run & !(valid_q & stall_i) & !boot_start_i;
   assign accept        = fetch_req_i & fetch_ready_o;
   assign fetch_valid_o = valid_q;
   assign fetch_pc_o    = pc_q;
   assign fetch_inst_o  = inst_q;
   assign fetch_err_o   = err_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = rom_we_o ? cnt_q + 1'b1 : cnt_q;
      ovf_d   = ovf_q | (hs & full);
      if (hs && ld_last_i) state_d = ST_RUN;
      if (run && boot_start_i) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end
      // flush and boot_start both kill whatever would be presented next cycle
      valid_d = run & !boot_start_i & !flush_i & (accept | hold);
      pc_d    = (accept && !flush_i) ? fetch_addr_i : pc_q;
      inst_d  = (accept && !flush_i) ? (ok ? rom_rdata_i : NOP) : inst_q;
      err_d   = (accept && !flush_i) ? !ok : err_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= BOOT_EN ? ST_LOAD : ST_RUN;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed bench for imem_ctrl with a big-endian byte ROM model.
module tb_imem_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        ld_valid_i = 1'b0;
   logic [7:0]  ld_data_i = '0;
   logic        ld_last_i = 1'b0;
   logic        ld_ready_o, ld_ovf_o;
   logic        boot_start_i = 1'b0;
   logic        boot_done_o;
   logic        fetch_req_i = 1'b0;
   logic [31:0] fetch_addr_i = '0;
   logic        fetch_ready_o;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        fetch_valid_o;
   logic [31:0] fetch_pc_o, fetch_inst_o;
   logic        fetch_err_o;
   logic        rom_we_o;
   logic [11:0] rom_waddr_o;
   logic [7:0]  rom_wdata_o;
   logic [11:0] rom_raddr_o;
   logic [31:0] rom_rdata_i;
   logic [7:0]  rom [0:4095];
   int checks = 0;
   int errors = 0;
   int writes;
   logic [7:0] img [0:7] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) if (rom_we_o) rom[rom_waddr_o] <= rom_wdata_o;
   assign rom_rdata_i = {rom[rom_raddr_o], rom[rom_raddr_o + 12'd1], rom[rom_raddr_o + 12'd2], rom[rom_raddr_o + 12'd3]};

   imem_ctrl dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
      .ld_ready_o(ld_ready_o), .ld_ovf_o(ld_ovf_o),
      .boot_start_i(boot_start_i), .boot_done_o(boot_done_o),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_ready_o(fetch_ready_o),
      .stall_i(stall_i), .flush_i(flush_i),
      .fetch_valid_o(fetch_valid_o), .fetch_pc_o(fetch_pc_o), .fetch_inst_o(fetch_inst_o),
      .fetch_err_o(fetch_err_o),
      .rom_we_o(rom_we_o), .rom_waddr_o(rom_waddr_o), .rom_wdata_o(rom_wdata_o),
      .rom_raddr_o(rom_raddr_o), .rom_rdata_i(rom_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_valid", fetch_valid_o, 0);
      chk("rst_pc", fetch_pc_o, 0);
      chk("rst_inst", fetch_inst_o, 0);
      chk("rst_err", fetch_err_o, 0);
      chk("rst_ovf", ld_ovf_o, 0);
      chk("rst_ld_ready", ld_ready_o, 1);
      chk("rst_done", boot_done_o, 0);
      chk("rst_fready", fetch_ready_o, 0);
      step();
      rst_n_i = 1'b1;
      step();
      // load 8-byte image
      for (int i = 0; i < 8; i++) begin
         ld_valid_i = 1'b1;
         ld_data_i  = img[i];
         ld_last_i  = (i == 7);
         #1;
         chk("ld_we", rom_we_o, 1);
         chk("ld_waddr", 32'(rom_waddr_o), i);
         chk("ld_wdata", 32'(rom_wdata_o), 32'(img[i]));
         chk("ld_done_low", boot_done_o, 0);
         step();
      end
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
      #1;
      chk("boot_done", boot_done_o, 1);
      chk("run_ld_ready", ld_ready_o, 0);
      chk("run_we", rom_we_o, 0);
      // single fetch
      fetch_req_i  = 1'b1;
      fetch_addr_i = 32'h8000_0004;
      #1;
      chk("f1_ready", fetch_ready_o, 1);
      chk("f1_raddr", 32'(rom_raddr_o), 4);
      step();
      chk("f1_valid", fetch_valid_o, 1);
      chk("f1_pc", fetch_pc_o, 32'h8000_0004);
      chk("f1_inst", fetch_inst_o, 32'h9300_1000);
      chk("f1_err", fetch_err_o, 0);
      // stall holds response while address changes
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_addr_i = 32'h8000_0000 + 32'(i * 8);
         #1;
         chk("st_ready", fetch_ready_o, 0);
         step();
         chk("st_valid", fetch_valid_o, 1);
         chk("st_pc", fetch_pc_o, 32'h8000_0004);
         chk("st_inst", fetch_inst_o, 32'h9300_1000);
      end
      stall_i = 1'b0;
      fetch_addr_i = 32'h8000_0000;
      #1;
      chk("st_rel_ready", fetch_ready_o, 1);
      step();
      chk("st_rel_valid", fetch_valid_o, 1);
      chk("st_rel_pc", fetch_pc_o, 32'h8000_0000);
      chk("st_rel_inst", fetch_inst_o, 32'h1300_0000);
      // flush on accept
      flush_i = 1'b1;
      #1;
      chk("fl_ready", fetch_ready_o, 1);
      step();
      chk("fl_valid", fetch_valid_o, 0);
      flush_i = 1'b0;
      fetch_req_i = 1'b0;
      step();
      chk("idle_valid", fetch_valid_o, 0);
      chk("idle_pc", fetch_pc_o, 32'h8000_0000);
      // error responses
      fetch_req_i  = 1'b1;
      fetch_addr_i = 32'h8000_1000;
      step();
      chk("oor_valid", fetch_valid_o, 1);
      chk("oor_pc", fetch_pc_o, 32'h8000_1000);
      chk("oor_inst", fetch_inst_o, 32'h0000_0013);
      chk("oor_err", fetch_err_o, 1);
      fetch_addr_i = 32'h8000_0002;
      step();
      chk("mis_pc", fetch_pc_o, 32'h8000_0002);
      chk("mis_inst", fetch_inst_o, 32'h0000_0013);
      chk("mis_err", fetch_err_o, 1);
      fetch_addr_i = 32'h7FFF_FFFC;
      step();
      chk("low_inst", fetch_inst_o, 32'h0000_0013);
      chk("low_err", fetch_err_o, 1);
      fetch_addr_i = 32'h8000_0FFC;
      step();
      chk("top_err", fetch_err_o, 0);
      // re-enter LOAD; a request in the boot_start cycle is refused
      boot_start_i = 1'b1;
      #1;
      chk("bs_ready", fetch_ready_o, 0);
      step();
      boot_start_i = 1'b0;
      fetch_req_i  = 1'b0;
      chk("bs_valid", fetch_valid_o, 0);
      chk("bs_done", boot_done_o, 0);
      chk("bs_ld_ready", ld_ready_o, 1);
      // overflow load
      writes = 0;
      ld_valid_i = 1'b1;
      for (int i = 0; i < 4097; i++) begin
         ld_data_i = 8'(i);
         #1;
         if (rom_we_o) writes++;
         if (i == 4096) chk("ovf_last_we", rom_we_o, 0);
         step();
      end
      chk("ovf_writes", writes, 4096);
      chk("ovf_flag", ld_ovf_o, 1);
      chk("ovf_still_load", boot_done_o, 0);
      step();
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("arst_ovf", ld_ovf_o, 0);
      chk("arst_valid", fetch_valid_o, 0);
      chk("arst_pc", fetch_pc_o, 0);
      chk("arst_inst", fetch_inst_o, 0);
      chk("arst_err", fetch_err_o, 0);
      chk("arst_waddr", 32'(rom_waddr_o), 0);
      step();
      rst_n_i = 1'b1;
      ld_data_i = 8'hA5;
      #1;
      chk("post_we", rom_we_o, 1);
      chk("post_waddr", 32'(rom_waddr_o), 0);
      step();
      ld_valid_i = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
